// File: rtl/sdp_ram_if.sv
// ----------------------------------------------------------------------------
// sdp_ram_if
//   Bundles the write port (A) and read port (B) of sdp_ram.
//   Signal protocol: there is no valid/ready handshake. wea qualifies a write
//   of dina to addra at the rising clock edge. enb qualifies a read of addrb
//   into the RAM register. rstb/regceb clear or enable the output register.
//   The memory never stalls its caller.
//   Ports (master = caller, slave = RAM):
//     addra  [AW]  write address        dina   [DW] write data
//     wea          write enable         addrb  [AW] read address
//     enb          read enable          rstb        output register clear
//     regceb       output register CE   doutb  [DW] read data (slave drives)
// ----------------------------------------------------------------------------
interface sdp_ram_if #(
   parameter int AW = 10,
   parameter int DW = 68
);
   logic [AW-1:0] addra;
   logic [DW-1:0] dina;
   logic          wea;
   logic [AW-1:0] addrb;
   logic          enb;
   logic          rstb;
   logic          regceb;
   logic [DW-1:0] doutb;

   modport master (
      output addra, dina, wea, addrb, enb, rstb, regceb,
      input  doutb
   );

   modport slave (
      input  addra, dina, wea, addrb, enb, rstb, regceb,
      output doutb
   );
endinterface

// File: rtl/sdp_ram.sv
// ----------------------------------------------------------------------------
// sdp_ram
//   Simple dual-port RAM with one write port and one registered read port,
//   both on a single clock. The array has no reset, so it maps to block RAM.
//   RAM_PERFORMANCE selects the read latency:
//     "HIGH_PERFORMANCE" gives a 2-cycle read through an extra output register.
//     "LOW_LATENCY"      gives a 1-cycle read.
//   Ports:
//     clk      rising-edge clock for both ports
//     reset_n  async active-low reset; clears the read registers, not the array
//     bus      sdp_ram_if slave (addra/dina/wea, addrb/enb/rstb/regceb, doutb)
// ----------------------------------------------------------------------------
module sdp_ram #(
   parameter int    RAM_WIDTH       = 68,
   parameter int    RAM_DEPTH       = 1024,
   parameter string RAM_PERFORMANCE = "HIGH_PERFORMANCE",
   parameter string INIT_FILE       = ""
) (
   input logic      clk,
   input logic      reset_n,
   sdp_ram_if.slave bus
);
   localparam int AW = (RAM_DEPTH > 1) ? $clog2(RAM_DEPTH) : 1;

   // Storage powers up as all zero.
   logic [RAM_WIDTH-1:0] mem [RAM_DEPTH] = '{default: '0};

   // Address range qualifiers. With a power-of-two depth every address is
   // valid. Otherwise, writes above the top word are dropped and reads there
   // return zero.
   logic wr_ok;
   logic rd_ok;
   if ((2 ** AW) == RAM_DEPTH) begin : g_full_range
      assign wr_ok = 1'b1;
      assign rd_ok = 1'b1;
   end else begin : g_part_range
      assign wr_ok = (int'(bus.addra) < RAM_DEPTH);
      assign rd_ok = (int'(bus.addrb) < RAM_DEPTH);
   end

   // Write port. It does not depend on reset_n.
   always_ff @(posedge clk) begin
      if (bus.wea && wr_ok) begin
         mem[bus.addra] <= bus.dina;
      end
   end

   // Read stage 1. The non-blocking write above makes a same-address read in
   // the same cycle return the old word (read-first).
   logic [RAM_WIDTH-1:0] rd_word;
   logic [RAM_WIDTH-1:0] ram_d;
   logic [RAM_WIDTH-1:0] ram_q;

   assign rd_word = rd_ok ? mem[bus.addrb] : '0;

   always_comb begin
      ram_d = ram_q;
      if (bus.enb) begin
         ram_d = rd_word;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         ram_q <= '0;
      end else begin
         ram_q <= ram_d;
      end
   end

   // Read stage 2 (output register) or a direct output.
   if (RAM_PERFORMANCE == "LOW_LATENCY") begin : g_low_latency
      // The output-register controls have no effect in this build.
      logic unused_out_ctrl;
      assign unused_out_ctrl = bus.rstb ^ bus.regceb;
      assign bus.doutb       = ram_q;
   end else begin : g_high_perf
      logic [RAM_WIDTH-1:0] out_d;
      logic [RAM_WIDTH-1:0] out_q;

      // rstb has priority over regceb.
      always_comb begin
         out_d = out_q;
         if (bus.rstb) begin
            out_d = '0;
         end else if (bus.regceb) begin
            out_d = ram_q;
         end
      end

      always_ff @(posedge clk or negedge reset_n) begin
         if (!reset_n) begin
            out_q <= '0;
         end else begin
            out_q <= out_d;
         end
      end

      assign bus.doutb = out_q;
   end
endmodule

// File: tb/tb_sdp_ram.sv
// ----------------------------------------------------------------------------
// tb_sdp_ram
//   Drives the same stimulus into a HIGH_PERFORMANCE and a LOW_LATENCY build.
//   A third build has a non-power-of-two depth (20 words) and gets its own
//   stimulus to cover out-of-range addresses.
// ----------------------------------------------------------------------------
module tb_sdp_ram;
   localparam int W     = 68;
   localparam int AW    = 10;
   localparam int NP_D  = 20;
   localparam int NP_AW = 5;

   logic clk;
   logic reset_n;

   sdp_ram_if #(.AW(AW),    .DW(W)) if_hp ();
   sdp_ram_if #(.AW(AW),    .DW(W)) if_ll ();
   sdp_ram_if #(.AW(NP_AW), .DW(W)) if_np ();

   sdp_ram #(.RAM_WIDTH(W), .RAM_DEPTH(1024), .RAM_PERFORMANCE("HIGH_PERFORMANCE"), .INIT_FILE(""))
      dut_hp (.clk(clk), .reset_n(reset_n), .bus(if_hp));
   sdp_ram #(.RAM_WIDTH(W), .RAM_DEPTH(1024), .RAM_PERFORMANCE("LOW_LATENCY"), .INIT_FILE(""))
      dut_ll (.clk(clk), .reset_n(reset_n), .bus(if_ll));
   sdp_ram #(.RAM_WIDTH(W), .RAM_DEPTH(NP_D), .RAM_PERFORMANCE("LOW_LATENCY"), .INIT_FILE(""))
      dut_np (.clk(clk), .reset_n(reset_n), .bus(if_np));

   // ---------------- clock ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- scoreboard counters ----------------
   int checks   = 0;
   int failures = 0;

   task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s t=%0t actual=%h expected=%h", name, $time, act, exp);
      end
   endtask

   // ---------------- reference model ----------------
   // Word arrays plus the value each read port is expected to present.
   logic [W-1:0] m_mem [1024];
   logic [W-1:0] m_np  [NP_D];
   logic [W-1:0] m_stage1;
   logic [W-1:0] m_out;
   logic [W-1:0] m_np_stage1;

   // Inputs are stable at the edge. The model reads the old contents before
   // applying the write.
   task automatic tick();
      logic [W-1:0] rd;
      @(posedge clk);
      if (!reset_n) begin
         m_stage1    = '0;
         m_out       = '0;
         m_np_stage1 = '0;
      end else begin
         if (if_hp.rstb)        m_out = '0;
         else if (if_hp.regceb) m_out = m_stage1;
         if (if_hp.enb) m_stage1 = m_mem[if_hp.addrb];
         if (if_np.enb) begin
            rd = '0;
            if (int'(if_np.addrb) < NP_D) rd = m_np[if_np.addrb];
            m_np_stage1 = rd;
         end
      end
      if (if_hp.wea) m_mem[if_hp.addra] = if_hp.dina;
      if (if_np.wea && (int'(if_np.addra) < NP_D)) m_np[if_np.addra] = if_np.dina;
      #1;
      check("model_hp", if_hp.doutb, m_out);
      check("model_ll", if_ll.doutb, m_stage1);
      check("model_np", if_np.doutb, m_np_stage1);
   endtask

   // ---------------- driver tasks ----------------
   task automatic drive(input logic wea, input logic [AW-1:0] addra, input logic [W-1:0] dina,
                        input logic enb, input logic [AW-1:0] addrb,
                        input logic rstb, input logic regceb);
      if_hp.wea = wea;  if_hp.addra = addra; if_hp.dina = dina;
      if_hp.enb = enb;  if_hp.addrb = addrb; if_hp.rstb = rstb; if_hp.regceb = regceb;
      if_ll.wea = wea;  if_ll.addra = addra; if_ll.dina = dina;
      if_ll.enb = enb;  if_ll.addrb = addrb; if_ll.rstb = rstb; if_ll.regceb = regceb;
   endtask

   task automatic drive_np(input logic wea, input logic [NP_AW-1:0] addra, input logic [W-1:0] dina,
                           input logic enb, input logic [NP_AW-1:0] addrb);
      if_np.wea = wea; if_np.addra = addra; if_np.dina = dina;
      if_np.enb = enb; if_np.addrb = addrb; if_np.rstb = 1'b0; if_np.regceb = 1'b0;
   endtask

   // ---------------- directed vector table ----------------
   typedef struct {
      logic          wea;
      logic [AW-1:0] addra;
      logic [W-1:0]  dina;
      logic          enb;
      logic [AW-1:0] addrb;
      logic          rstb;
      logic          regceb;
      logic [W-1:0]  exp_ll;
      logic [W-1:0]  exp_hp;
   } vec_t;

   function automatic vec_t mk(input logic wea, input int a, input logic [W-1:0] d,
                               input logic enb, input int b, input logic rstb, input logic ce,
                               input logic [W-1:0] ell, input logic [W-1:0] ehp);
      vec_t v;
      v.wea = wea; v.addra = AW'(a); v.dina = d; v.enb = enb; v.addrb = AW'(b);
      v.rstb = rstb; v.regceb = ce; v.exp_ll = ell; v.exp_hp = ehp;
      return v;
   endfunction

   localparam logic [W-1:0] V = 68'hDEADBEEF012345678;

   function automatic logic [W-1:0] pat(input int i);
      return W'(i * 32'h01010101 + 7);
   endfunction

   vec_t tbl [10];

   initial begin
      for (int i = 0; i < 1024; i++) m_mem[i] = '0;
      for (int i = 0; i < NP_D; i++) m_np[i] = '0;
      m_stage1 = '0; m_out = '0; m_np_stage1 = '0;

      //          wea a  dina     enb b  rstb ce   exp_ll  exp_hp
      tbl[0] = mk(1, 5, V,        0, 0, 0,   0,   '0,     '0);
      tbl[1] = mk(1, 7, W'(1),    1, 5, 0,   1,   V,      '0);    // 1-cycle latency
      tbl[2] = mk(1, 7, W'(2),    1, 7, 0,   1,   W'(1),  V);     // read-first; HP 2-cycle
      tbl[3] = mk(0, 0, '0,       1, 7, 0,   1,   W'(2),  W'(1));
      tbl[4] = mk(0, 0, '0,       0, 5, 0,   1,   W'(2),  W'(2)); // enb=0 holds stage 1
      tbl[5] = mk(0, 0, '0,       1, 5, 1,   1,   V,      '0);    // rstb wins over regceb
      tbl[6] = mk(0, 0, '0,       0, 3, 0,   1,   V,      V);
      tbl[7] = mk(0, 0, '0,       1, 9, 0,   0,   '0,     V);     // regceb=0 holds
      tbl[8] = mk(0, 0, '0,       1, 7, 0,   0,   W'(2),  V);
      tbl[9] = mk(0, 0, '0,       0, 0, 0,   1,   W'(2),  W'(2));

      // ---- reset state ----
      reset_n = 1'b0;
      drive(0, '0, '0, 0, '0, 0, 0);
      drive_np(0, '0, '0, 0, '0);
      repeat (2) @(posedge clk);
      #1;
      check("reset_hp", if_hp.doutb, '0);
      check("reset_ll", if_ll.doutb, '0);
      check("reset_np", if_np.doutb, '0);
      reset_n = 1'b1;

      // ---- table ----
      for (int i = 0; i < 10; i++) begin
         drive(tbl[i].wea, tbl[i].addra, tbl[i].dina, tbl[i].enb, tbl[i].addrb,
               tbl[i].rstb, tbl[i].regceb);
         tick();
         check($sformatf("tbl%0d_ll", i), if_ll.doutb, tbl[i].exp_ll);
         check($sformatf("tbl%0d_hp", i), if_hp.doutb, tbl[i].exp_hp);
      end

      // ---- async reset mid-stream; writes still land, contents survive ----
      reset_n = 1'b0;
      #2;
      check("async_rst_hp", if_hp.doutb, '0);
      check("async_rst_ll", if_ll.doutb, '0);
      drive(1, AW'(10), W'(68'h123), 1, AW'(5), 0, 1);
      tick();
      check("in_rst_hp", if_hp.doutb, '0);
      check("in_rst_ll", if_ll.doutb, '0);
      reset_n = 1'b1;
      drive(0, '0, '0, 1, AW'(5), 0, 1);
      tick();
      check("post_rst_ll", if_ll.doutb, V);
      check("post_rst_hp0", if_hp.doutb, '0);
      drive(0, '0, '0, 1, AW'(10), 0, 1);
      tick();
      check("rst_write_ll", if_ll.doutb, W'(68'h123));
      check("post_rst_hp", if_hp.doutb, V);

      // ---- unwritten address reads zero ----
      drive(0, '0, '0, 1, AW'(100), 0, 1);
      tick();
      check("unwritten_ll", if_ll.doutb, '0);

      // ---- fill 0..31, then stream reads back-to-back ----
      for (int i = 0; i < 32; i++) begin
         drive(1, AW'(i), pat(i), 0, '0, 0, 0);
         tick();
      end
      for (int i = 0; i < 34; i++) begin
         drive(0, '0, '0, (i < 32), AW'(i), 0, 1);
         tick();
         if (i < 32) check($sformatf("stream_ll%0d", i), if_ll.doutb, pat(i));
         if (i >= 1 && i <= 32) check($sformatf("stream_hp%0d", i), if_hp.doutb, pat(i - 1));
      end

      // ---- enb=0 with a wandering address keeps output steady ----
      for (int i = 0; i < 4; i++) begin
         drive(0, '0, '0, 0, AW'($urandom_range(0, 1023)), 0, 0);
         tick();
         check("enb_off_ll", if_ll.doutb, pat(31));
         check("enb_off_hp", if_hp.doutb, pat(31));
      end

      // ---- randomized traffic against the model ----
      for (int n = 0; n < 1500; n++) begin
         logic [W-1:0] d;
         int           a;
         int           b;
         d = {4'($urandom), $urandom, $urandom};
         a = ($urandom_range(0, 7) == 0) ? $urandom_range(1020, 1023) : $urandom_range(0, 15);
         b = ($urandom_range(0, 7) == 0) ? $urandom_range(1020, 1023) : $urandom_range(0, 15);
         drive($urandom_range(0, 1), AW'(a), d, $urandom_range(0, 3) != 0, AW'(b),
               $urandom_range(0, 15) == 0, $urandom_range(0, 3) != 0);
         drive_np($urandom_range(0, 1), NP_AW'($urandom_range(0, 31)), ~d,
                  $urandom_range(0, 3) != 0, NP_AW'($urandom_range(0, 31)));
         tick();
      end

      // ---- out-of-range on the 20-word build: write 25 dropped, read 25 is zero ----
      drive(0, '0, '0, 0, '0, 0, 0);
      drive_np(1, NP_AW'(25), W'(68'h55), 0, '0);
      tick();
      drive_np(1, NP_AW'(19), W'(68'h77), 1, NP_AW'(25));
      tick();
      check("np_oob_rd", if_np.doutb, '0);
      drive_np(0, '0, '0, 1, NP_AW'(19));
      tick();
      check("np_top_word", if_np.doutb, W'(68'h77));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
